// File: rtl/char_rain_engine.sv
// Falling-character game state: per-column slot table read by the VGA renderer,
// advanced once per frame, spawned from an LFSR, and cleared by matching key presses.
module char_rain_engine #(
    parameter int          NUM_COLS     = 72,
    parameter int          COL_LO       = 5,
    parameter int          COL_HI       = 67,
    parameter int          FALL_STEP    = 1,
    parameter int          BOTTOM       = 464,
    parameter int          SPAWN_PERIOD = 30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     key_valid,
    input  logic [7:0]               key_ascii,
    output logic [NUM_COLS*10-1:0]   mem_ascii,
    output logic [NUM_COLS*10-1:0]   mem_row,
    output logic [NUM_COLS-1:0]      mem_valid,
    output logic [9:0]               score,
    output logic [9:0]               miss,
    output logic                     busy
);

    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int NPLAY = COL_HI - COL_LO + 1;
    localparam logic [9:0] SAT = 10'd999;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SCAN       = 3'd1;
    localparam logic [2:0] S_SPAWN      = 3'd2;
    localparam logic [2:0] S_HIT        = 3'd3;
    localparam logic [2:0] S_HIT_COMMIT = 3'd4;

    logic [2:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_spawn_cnt;
    logic [15:0]       r_lfsr;
    logic              r_pend_frame;
    logic              r_pend_key;
    logic [7:0]        r_key_buf;
    logic [7:0]        r_hit_key;
    logic              r_best_found;
    logic [IDX_W-1:0]  r_best_idx;
    logic [9:0]        r_best_row;
    logic [NUM_COLS-1:0] r_valid;
    logic [9:0]        r_row   [NUM_COLS];
    logic [7:0]        r_ascii [NUM_COLS];
    logic [9:0]        r_score;
    logic [9:0]        r_miss;

    logic [10:0]       w_nrow;
    logic              w_fall_out;
    logic              w_last_scan;
    logic              w_last_hit;
    logic              w_better;
    logic [IDX_W-1:0]  w_spawn_col;
    logic [7:0]        w_spawn_ch;
    logic [15:0]       w_lfsr_nxt;
    logic              w_take_key;

    // 11-bit sum so a row near the top of the 10-bit range cannot wrap past BOTTOM
    assign w_nrow      = {1'b0, r_row[r_idx]} + 11'(FALL_STEP);
    assign w_fall_out  = (w_nrow >= 11'(BOTTOM));
    assign w_last_scan = (r_idx == IDX_W'(NUM_COLS - 1));
    assign w_last_hit  = (r_idx == IDX_W'(COL_HI));
    assign w_better    = r_valid[r_idx] && (r_ascii[r_idx] == r_hit_key) &&
                         (!r_best_found || (r_row[r_idx] > r_best_row));
    assign w_spawn_col = IDX_W'(r_lfsr % 16'(NPLAY)) + IDX_W'(COL_LO);
    assign w_spawn_ch  = 8'h61 + (r_lfsr[15:8] % 8'd26);
    assign w_lfsr_nxt  = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    assign w_take_key  = key_valid && !r_pend_key;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_spawn_cnt  <= '0;
            r_lfsr       <= LFSR_SEED;
            r_pend_frame <= 1'b0;
            r_pend_key   <= 1'b0;
            r_key_buf    <= '0;
            r_hit_key    <= '0;
            r_best_found <= 1'b0;
            r_best_idx   <= '0;
            r_best_row   <= '0;
            r_valid      <= '0;
            r_score      <= '0;
            r_miss       <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                r_row[i]   <= '0;
                r_ascii[i] <= '0;
            end
        end else begin
            if (r_state != S_IDLE) begin
                if (frame_tick) r_pend_frame <= 1'b1;
                if (w_take_key) begin
                    r_pend_key <= 1'b1;
                    r_key_buf  <= key_ascii;
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (frame_tick || r_pend_frame) begin
                        r_state      <= S_SCAN;
                        r_pend_frame <= 1'b0;
                        if (w_take_key) begin
                            r_pend_key <= 1'b1;
                            r_key_buf  <= key_ascii;
                        end
                    end else if (key_valid || r_pend_key) begin
                        // r_hit_key is separate so a key queued during HIT can't disturb the search
                        r_state      <= S_HIT;
                        r_pend_key   <= 1'b0;
                        r_hit_key    <= r_pend_key ? r_key_buf : key_ascii;
                        r_best_found <= 1'b0;
                        r_idx        <= IDX_W'(COL_LO);
                    end
                end

                S_SCAN: begin
                    if (r_valid[r_idx]) begin
                        if (w_fall_out) begin
                            r_valid[r_idx] <= 1'b0;
                            r_row[r_idx]   <= '0;
                            if (r_miss != SAT) r_miss <= r_miss + 10'd1;
                        end else begin
                            r_row[r_idx] <= w_nrow[9:0];
                        end
                    end
                    if (w_last_scan) begin
                        if (r_spawn_cnt == CNT_W'(SPAWN_PERIOD - 1)) begin
                            r_spawn_cnt <= '0;
                            r_state     <= S_SPAWN;
                        end else begin
                            r_spawn_cnt <= r_spawn_cnt + 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                S_SPAWN: begin
                    if (!r_valid[w_spawn_col]) begin
                        r_valid[w_spawn_col] <= 1'b1;
                        r_row[w_spawn_col]   <= '0;
                        r_ascii[w_spawn_col] <= w_spawn_ch;
                    end
                    r_lfsr  <= w_lfsr_nxt;
                    r_state <= S_IDLE;
                end

                S_HIT: begin
                    // strict '>' while walking upward keeps the lower index on equal rows
                    if (w_better) begin
                        r_best_found <= 1'b1;
                        r_best_idx   <= r_idx;
                        r_best_row   <= r_row[r_idx];
                    end
                    if (w_last_hit) r_state <= S_HIT_COMMIT;
                    else            r_idx   <= r_idx + 1'b1;
                end

                S_HIT_COMMIT: begin
                    if (r_best_found) begin
                        r_valid[r_best_idx] <= 1'b0;
                        r_row[r_best_idx]   <= '0;
                        if (r_score != SAT) r_score <= r_score + 10'd1;
                    end
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_out
        assign mem_ascii[g*10 +: 10] = {2'b00, r_ascii[g]};
        assign mem_row[g*10 +: 10]   = r_row[g];
    end

    assign mem_valid = r_valid;
    assign score     = r_score;
    assign miss      = r_miss;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_char_rain_engine.sv
// Random play against a slot-table reference model; a small second instance reaches saturation.
module tb_char_rain_engine;

    logic clk = 1'b0;
    logic reset;
    logic [1:0]      ft, kv;
    logic [1:0][7:0] ka;

    logic [719:0] a0, r0;
    logic [71:0]  v0;
    logic [9:0]   s0, x0;
    logic         b0;
    logic [79:0]  a1, r1;
    logic [7:0]   v1;
    logic [9:0]   s1, x1;
    logic         b1;

    always #5 clk = ~clk;

    char_rain_engine u_main (
        .clk(clk), .reset(reset), .frame_tick(ft[0]), .key_valid(kv[0]), .key_ascii(ka[0]),
        .mem_ascii(a0), .mem_row(r0), .mem_valid(v0), .score(s0), .miss(x0), .busy(b0)
    );

    char_rain_engine #(
        .NUM_COLS(8), .COL_LO(1), .COL_HI(6), .FALL_STEP(1), .BOTTOM(1),
        .SPAWN_PERIOD(1), .LFSR_SEED(16'h1234)
    ) u_small (
        .clk(clk), .reset(reset), .frame_tick(ft[1]), .key_valid(kv[1]), .key_ascii(ka[1]),
        .mem_ascii(a1), .mem_row(r1), .mem_valid(v1), .score(s1), .miss(x1), .busy(b1)
    );

    localparam int          P_NC  [2] = '{72, 8};
    localparam int          P_LO  [2] = '{5, 1};
    localparam int          P_HI  [2] = '{67, 6};
    localparam int          P_BOT [2] = '{464, 1};
    localparam int          P_SP  [2] = '{30, 1};
    localparam logic [15:0] P_SEED[2] = '{16'hACE1, 16'h1234};

    int          n_chk = 0;
    int          n_fail = 0;
    int          mrow [2][72];
    bit          mval [2][72];
    logic [7:0]  masc [2][72];
    int          msc [2];
    int          mms [2];
    int          mcnt[2];
    logic [15:0] mlfsr[2];

    task automatic check(input string tag, input logic [719:0] got, input logic [719:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < 72; c++) begin
                mrow[u][c] = 0;
                mval[u][c] = 1'b0;
                masc[u][c] = 8'h00;
            end
            msc[u] = 0; mms[u] = 0; mcnt[u] = 0;
            mlfsr[u] = P_SEED[u];
        end
    endfunction

    function automatic void model_frame(input int u);
        int col;
        logic [7:0] ch;
        for (int c = 0; c < P_NC[u]; c++) begin
            if (mval[u][c]) begin
                if (mrow[u][c] + 1 >= P_BOT[u]) begin
                    mval[u][c] = 1'b0;
                    mrow[u][c] = 0;
                    if (mms[u] < 999) mms[u]++;
                end else begin
                    mrow[u][c] = mrow[u][c] + 1;
                end
            end
        end
        mcnt[u]++;
        if (mcnt[u] == P_SP[u]) begin
            mcnt[u] = 0;
            col = P_LO[u] + int'(mlfsr[u]) % (P_HI[u] - P_LO[u] + 1);
            ch  = 8'h61 + 8'(int'(mlfsr[u][15:8]) % 26);
            if (!mval[u][col]) begin
                mval[u][col] = 1'b1;
                mrow[u][col] = 0;
                masc[u][col] = ch;
            end
            mlfsr[u] = {mlfsr[u][0] ^ mlfsr[u][2] ^ mlfsr[u][3] ^ mlfsr[u][5], mlfsr[u][15:1]};
        end
    endfunction

    function automatic void model_key(input int u, input logic [7:0] k);
        int best = -1;
        for (int c = P_LO[u]; c <= P_HI[u]; c++)
            if (mval[u][c] && masc[u][c] == k && (best < 0 || mrow[u][c] > mrow[u][best]))
                best = c;
        if (best >= 0) begin
            mval[u][best] = 1'b0;
            mrow[u][best] = 0;
            if (msc[u] < 999) msc[u]++;
        end
    endfunction

    function automatic logic [719:0] exp_vec(input int u, input int which);
        logic [719:0] v = '0;
        for (int c = 0; c < P_NC[u]; c++) begin
            case (which)
                0:       v[c] = mval[u][c];
                1:       v[c*10 +: 10] = 10'(mrow[u][c]);
                default: v[c*10 +: 10] = {2'b00, masc[u][c]};
            endcase
        end
        return v;
    endfunction

    function automatic logic [719:0] obs_vec(input int u, input int which);
        case (which)
            0:       return (u == 0) ? 720'(v0) : 720'(v1);
            1:       return (u == 0) ? r0 : 720'(r1);
            2:       return (u == 0) ? a0 : 720'(a1);
            3:       return (u == 0) ? 720'(s0) : 720'(s1);
            4:       return (u == 0) ? 720'(x0) : 720'(x1);
            default: return (u == 0) ? 720'(b0) : 720'(b1);
        endcase
    endfunction

    task automatic check_state(input int u, input string tag);
        check($sformatf("u%0d %s valid", u, tag), obs_vec(u, 0), exp_vec(u, 0));
        check($sformatf("u%0d %s row", u, tag),   obs_vec(u, 1), exp_vec(u, 1));
        check($sformatf("u%0d %s ascii", u, tag), obs_vec(u, 2), exp_vec(u, 2));
        check($sformatf("u%0d %s score", u, tag), obs_vec(u, 3), 720'(msc[u]));
        check($sformatf("u%0d %s miss", u, tag),  obs_vec(u, 4), 720'(mms[u]));
        check($sformatf("u%0d %s busy", u, tag),  obs_vec(u, 5), 720'(0));
    endtask

    task automatic pulse_frame(input int u);
        @(negedge clk); ft[u] = 1'b1;
        @(negedge clk); ft[u] = 1'b0;
    endtask

    task automatic pulse_key(input int u, input logic [7:0] k);
        @(negedge clk); kv[u] = 1'b1; ka[u] = k;
        @(negedge clk); kv[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u, input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 500) begin
            @(negedge clk);
            n++;
            if (obs_vec(u, 5) != '0) quiet = 0;
            else                     quiet++;
        end
        check($sformatf("u%0d %s idle", u, tag), 720'(quiet), 720'(3));
    endtask

    task automatic do_frame(input int u, input string tag);
        pulse_frame(u);
        wait_idle(u, tag);
        model_frame(u);
    endtask

    task automatic do_key(input int u, input logic [7:0] k, input string tag);
        pulse_key(u, k);
        wait_idle(u, tag);
        model_key(u, k);
    endtask

    function automatic logic [7:0] rand_letter();
        return 8'h61 + 8'($urandom_range(25));
    endfunction

    function automatic logic [7:0] pick_key(input int u);
        int q[$];
        for (int c = P_LO[u]; c <= P_HI[u]; c++) if (mval[u][c]) q.push_back(c);
        if (q.size() == 0) return rand_letter();
        return masc[u][q[$urandom_range(q.size() - 1)]];
    endfunction

    initial begin
        logic [7:0] k1, k2;
        ft = '0; kv = '0; ka = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state(0, "reset");
        check_state(1, "reset");
        reset = 1'b1;

        fork
            begin
                // long run without aimed keys: the first spawned char reaches 463 and is missed
                for (int f = 0; f < 496; f++) begin
                    do_frame(0, "p1f");
                    if ($urandom_range(7) == 0) do_key(0, rand_letter(), "p1k");
                    check_state(0, "p1");
                end
                for (int f = 0; f < 40; f++) begin
                    do_frame(0, "p2f");
                    if ($urandom_range(1) == 0) do_key(0, pick_key(0), "p2k");
                    check_state(0, "p2");
                end
            end
            begin
                for (int i = 0; i < 1005; i++) begin
                    do_frame(1, "satAf");
                    if (i % 7 == 0) do_key(1, rand_letter(), "satAr");
                    do_key(1, pick_key(1), "satAk");
                    check_state(1, "satA");
                end
                for (int i = 0; i < 1005; i++) begin
                    do_frame(1, "satB");
                    if (i % 50 == 0 || i > 995) check_state(1, "satB");
                end
            end
        join

        // frame and key together, then a second key while the first is still queued
        k1 = pick_key(0);
        k2 = pick_key(0);
        for (int t = 0; t < 8 && k2 == k1; t++) k2 = pick_key(0);
        @(negedge clk); ft[0] = 1'b1; kv[0] = 1'b1; ka[0] = k1;
        @(negedge clk); ft[0] = 1'b0; kv[0] = 1'b0;
        repeat (3) @(negedge clk);
        pulse_key(0, k2);
        wait_idle(0, "same");
        model_frame(0);
        model_key(0, k1);
        check_state(0, "same");

        k1 = pick_key(0);
        pulse_key(0, k1);
        repeat (4) @(negedge clk);
        pulse_frame(0);
        wait_idle(0, "keyframe");
        model_key(0, k1);
        model_frame(0);
        check_state(0, "keyframe");

        k1 = pick_key(0);
        pulse_frame(0);
        repeat (4) @(negedge clk);
        pulse_key(0, k1);
        wait_idle(0, "framekey");
        model_frame(0);
        model_key(0, k1);
        check_state(0, "framekey");

        pulse_frame(0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        check_state(0, "rstmid");
        check_state(1, "rstmid");

        for (int f = 0; f < 31; f++) do_frame(0, "post");
        check_state(0, "post");
        for (int f = 0; f < 3; f++) do_frame(1, "post");
        check_state(1, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
